// File: rtl/bounded_step_counter.sv
// bounded_step_counter: bounded up/down step counter with wrap/saturate modes,
// sticky overflow flag and a one-unit-per-cycle seek engine.
module bounded_step_counter #(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  EN_i,
   input  logic                  LOAD_i,
   input  logic                  DOWN_i,
   input  logic [WIDTH-1:0]      D_i,
   input  logic [STEP_WIDTH-1:0] STEP_i,
   input  logic [WIDTH-1:0]      LIMIT_i,
   input  logic                  SAT_i,
   input  logic                  OVF_CLR_i,
   input  logic                  SEEK_i,
   output logic [WIDTH-1:0]      Q_o,
   output logic                  ZERO_o,
   output logic                  AT_LIMIT_o,
   output logic                  WRAP_o,
   output logic                  OVF_o,
   output logic                  BUSY_o,
   output logic                  DONE_o
);
   localparam int XW = WIDTH + 2;
   localparam logic signed [XW-1:0] ONE = 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q;
   logic [WIDTH-1:0] q_q, t_q, q_d, ld_val;
   logic ovf_q, wrap_q, busy_q, done_q, ovf_set, wrap_d;
   logic signed [XW-1:0] qx, sx, lx, up_s, up_r, dn_r;

   function automatic logic [WIDTH-1:0] clamp(input logic signed [XW-1:0] r,
                                              input logic signed [XW-1:0] lim);
      return r[XW-1] ? '0 : (r > lim) ? lim[WIDTH-1:0] : r[WIDTH-1:0];
   endfunction

   // All bound arithmetic is signed with two guard bits so sums and negative wraps never alias.
   assign qx     = $signed(XW'(q_q));
   assign sx     = $signed(XW'(STEP_i));
   assign lx     = $signed(XW'(LIMIT_i));
   assign up_s   = qx + sx;
   assign up_r   = up_s - lx - ONE;
   assign dn_r   = qx + lx + ONE - sx;
   assign ld_val = (D_i > LIMIT_i) ? LIMIT_i : D_i;

   always_comb begin
      q_d     = q_q;
      ovf_set = 1'b0;
      wrap_d  = 1'b0;
      if (STEP_i != '0 && !DOWN_i) begin
         ovf_set = up_s > lx;
         wrap_d  = ovf_set && !SAT_i;
         q_d     = !ovf_set ? up_s[WIDTH-1:0] : SAT_i ? LIMIT_i : clamp(up_r, lx);
      end else if (STEP_i != '0) begin
         ovf_set = sx > qx;
         wrap_d  = ovf_set && !SAT_i;
         q_d     = !ovf_set ? q_q - WIDTH'(STEP_i) : SAT_i ? '0 : clamp(dn_r, lx);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         q_q     <= '0;
         t_q     <= '0;
         ovf_q   <= 1'b0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q  <= ovf_q && !OVF_CLR_i;
         case (state_q)
            RUN: begin
               if (q_q != t_q) begin
                  q_q <= (q_q < t_q) ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               if (SEEK_i) begin
                  t_q     <= ld_val;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end else if (EN_i && LOAD_i) begin
                  q_q <= ld_val;
               end else if (EN_i) begin
                  q_q    <= q_d;
                  wrap_q <= wrap_d;
                  ovf_q  <= ovf_set || (ovf_q && !OVF_CLR_i);
               end
            end
         endcase
      end
   end

   assign Q_o        = q_q;
   assign ZERO_o     = q_q == '0;
   assign AT_LIMIT_o = q_q == LIMIT_i;
   assign WRAP_o     = wrap_q;
   assign OVF_o      = ovf_q;
   assign BUSY_o     = busy_q;
   assign DONE_o     = done_q;
endmodule
